// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared constants, types and helpers for the fetch global
//               history register (GHR) speculation logic.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int GHR_WIDTH  = 8;
    localparam int CKPT_DEPTH = 8;
    localparam int TAG_W      = $clog2(CKPT_DEPTH);

    typedef logic [GHR_WIDTH-1:0] ghr_t;
    typedef logic [TAG_W-1:0]     ckpt_tag_t;
    typedef logic [TAG_W:0]       ckpt_cnt_t;

    // Shift one branch outcome into the youngest end of a history value.
    // The oldest bit falls off the top through the truncating cast.
    function automatic ghr_t ghr_shift(input ghr_t hist, input logic dir);
        return ghr_t'({hist, dir});
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_ghr_ckpt_ram.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ghr_ckpt_ram
// Description : CKPT_DEPTH x GHR_WIDTH checkpoint store. One synchronous
//               write port, one asynchronous read port. Contents are not
//               reset; liveness is tracked by the pointers in the parent.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ghr_ckpt_ram
    import fetch_pkg::*;
(
    input  logic                 clk,
    input  logic                 i_wen,
    input  logic [TAG_W-1:0]     i_waddr,
    input  logic [GHR_WIDTH-1:0] i_wdata,
    input  logic [TAG_W-1:0]     i_raddr,
    output logic [GHR_WIDTH-1:0] o_rdata
);

    ghr_t mem_q [CKPT_DEPTH];

    // Capture the pre-branch history into the allocated slot.
    always_ff @(posedge clk) begin
        if (i_wen) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    // Recovery needs the checkpoint in the same cycle as the mispredict.
    assign o_rdata = mem_q[i_raddr];

endmodule
`default_nettype wire

// File: rtl/fetch_ghr_spec.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ghr_spec
// Description : Speculative update and recovery controller for the fetch
//               GHR. Shifts predicted directions into the history,
//               checkpoints the pre-branch history in a circular buffer and
//               restores it (with the resolved direction) on a mispredict.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ghr_spec
    import fetch_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [GHR_WIDTH-1:0] i_ghr_rdata,
    output logic                 o_ghr_wen,
    output logic [GHR_WIDTH-1:0] o_ghr_wdata,
    input  logic                 i_pred_valid,
    input  logic                 i_pred_taken,
    output logic                 o_pred_ready,
    output logic [TAG_W-1:0]     o_pred_tag,
    input  logic                 i_cmt_valid,
    input  logic                 i_mis_valid,
    input  logic [TAG_W-1:0]     i_mis_tag,
    input  logic                 i_mis_taken,
    output logic [TAG_W:0]       o_ckpt_count,
    output logic                 o_empty,
    output logic                 o_full
);

    localparam ckpt_cnt_t CNT_FULL = ckpt_cnt_t'(CKPT_DEPTH);
    localparam ckpt_tag_t TAG_ONE  = ckpt_tag_t'(1);

    ckpt_tag_t wptr_q, wptr_d;
    ckpt_tag_t rptr_q, rptr_d;
    ckpt_cnt_t count_q, count_d;

    logic      empty;
    logic      full;
    logic      pred_ready;
    logic      do_alloc;
    logic      do_commit;
    logic      do_mis;
    ghr_t      ckpt_rdata;
    ckpt_tag_t mis_span_raw;
    ckpt_cnt_t mis_span;

    // Checkpoint storage: written on every accepted prediction, read by tag
    // on a mispredict.
    fetch_ghr_ckpt_ram u_ckpt_ram (
        .clk     (clk),
        .i_wen   (do_alloc),
        .i_waddr (wptr_q),
        .i_wdata (i_ghr_rdata),
        .i_raddr (i_mis_tag),
        .o_rdata (ckpt_rdata)
    );

    // Status and handshake decode; full/empty always reflect the count
    // before this cycle's updates.
    always_comb begin
        empty      = (count_q == '0);
        full       = (count_q == CNT_FULL);
        // A mispredict owns the GHR write port, so it blocks allocation.
        pred_ready = resetn && !full && !i_mis_valid;
        do_alloc   = i_pred_valid && pred_ready;
        do_commit  = resetn && i_cmt_valid && !empty;
        do_mis     = resetn && i_mis_valid;
        // Entries from rptr up to and including the mispredicted tag
        // survive. A zero modular distance can only mean the buffer was
        // full and the youngest entry mispredicted, so all entries stay.
        mis_span_raw = i_mis_tag + TAG_ONE - rptr_q;
        mis_span     = (mis_span_raw == '0) ? CNT_FULL
                                            : ckpt_cnt_t'(mis_span_raw);
    end

    // GHR write port: recovery from the checkpoint takes precedence over
    // the speculative shift.
    always_comb begin
        o_ghr_wen   = do_mis || do_alloc;
        o_ghr_wdata = ghr_shift(i_ghr_rdata, i_pred_taken);
        if (do_mis) begin
            o_ghr_wdata = ghr_shift(ckpt_rdata, i_mis_taken);
        end
    end

    // Next-state for the circular buffer pointers and occupancy.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (!resetn) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_mis) begin
                // Drop everything younger than the mispredicted branch.
                wptr_d  = i_mis_tag + TAG_ONE;
                count_d = mis_span - ckpt_cnt_t'(do_commit);
            end else begin
                if (do_alloc) begin
                    wptr_d = wptr_q + TAG_ONE;
                end
                count_d = count_q + ckpt_cnt_t'(do_alloc)
                                  - ckpt_cnt_t'(do_commit);
            end
            if (do_commit) begin
                rptr_d = rptr_q + TAG_ONE;
            end
        end
    end

    // Pointer and count registers; reset is folded into the next-state logic.
    always_ff @(posedge clk) begin
        wptr_q  <= wptr_d;
        rptr_q  <= rptr_d;
        count_q <= count_d;
    end

    assign o_pred_ready = pred_ready;
    assign o_pred_tag   = wptr_q;
    assign o_ckpt_count = count_q;
    assign o_empty      = empty;
    assign o_full       = full;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ghr_spec.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ghr_spec
// Description : Self-checking bench for fetch_ghr_spec. The bench owns the
//               GHR register and keeps a queue-based model of live
//               checkpoints (oldest first).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ghr_spec;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] ghr;
    logic       o_ghr_wen;
    logic [7:0] o_ghr_wdata;
    logic       i_pred_valid, i_pred_taken;
    logic       o_pred_ready;
    logic [2:0] o_pred_tag;
    logic       i_cmt_valid, i_mis_valid, i_mis_taken;
    logic [2:0] i_mis_tag;
    logic [3:0] o_ckpt_count;
    logic       o_empty, o_full;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         tag;
        logic [7:0] hist;
    } ent_t;

    ent_t q[$];
    int   head = 0;

    always #5 clk = ~clk;

    fetch_ghr_spec dut (
        .clk          (clk),
        .resetn       (rstn),
        .i_ghr_rdata  (ghr),
        .o_ghr_wen    (o_ghr_wen),
        .o_ghr_wdata  (o_ghr_wdata),
        .i_pred_valid (i_pred_valid),
        .i_pred_taken (i_pred_taken),
        .o_pred_ready (o_pred_ready),
        .o_pred_tag   (o_pred_tag),
        .i_cmt_valid  (i_cmt_valid),
        .i_mis_valid  (i_mis_valid),
        .i_mis_tag    (i_mis_tag),
        .i_mis_taken  (i_mis_taken),
        .o_ckpt_count (o_ckpt_count),
        .o_empty      (o_empty),
        .o_full       (o_full)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check against the model, clock, update model.
    task automatic step(input logic pv, input logic pt, input logic cv,
                        input logic mv, input logic [2:0] mt, input logic mtk);
        int         sz;
        int         idx;
        logic       e_ready, e_alloc, e_commit, e_mis, e_wen;
        logic [7:0] e_wdata;
        logic       wen_s;
        logic [7:0] wd_s;
        i_pred_valid = pv;
        i_pred_taken = pt;
        i_cmt_valid  = cv;
        i_mis_valid  = mv;
        i_mis_tag    = mt;
        i_mis_taken  = mtk;
        #1;
        sz       = q.size();
        idx      = 0;
        e_ready  = rstn && (sz < 8) && !mv;
        e_alloc  = pv && e_ready;
        e_commit = rstn && cv && (sz > 0);
        e_mis    = rstn && mv;
        e_wen    = e_mis || e_alloc;
        e_wdata  = {ghr[6:0], pt};
        if (e_mis) begin
            idx = (int'(mt) - head + 8) % 8;
            if (idx >= sz) begin
                checks++;
                errors++;
                $error("FAIL mis_tag_not_live: observed=%0d expected=<%0d", idx, sz);
                idx = 0;
            end else begin
                e_wdata = {q[idx].hist[6:0], mtk};
            end
        end
        chk("count", 32'(o_ckpt_count), 32'(sz));
        chk("empty", 32'(o_empty), 32'(sz == 0));
        chk("full", 32'(o_full), 32'(sz == 8));
        chk("pred_ready", 32'(o_pred_ready), 32'(e_ready));
        chk("ghr_wen", 32'(o_ghr_wen), 32'(e_wen));
        if (e_wen) chk("ghr_wdata", 32'(o_ghr_wdata), 32'(e_wdata));
        if (e_alloc) chk("pred_tag", 32'(o_pred_tag), 32'((head + sz) % 8));
        wen_s = o_ghr_wen;
        wd_s  = o_ghr_wdata;
        @(posedge clk);
        #1;
        if (!rstn) begin
            q.delete();
            head = 0;
            ghr  = 8'h00;
        end else begin
            if (e_mis) begin
                while (q.size() > idx + 1) void'(q.pop_back());
            end
            if (e_alloc) q.push_back('{tag: (head + sz) % 8, hist: ghr});
            if (e_commit) begin
                void'(q.pop_front());
                head = (head + 1) % 8;
            end
            if (wen_s) ghr = wd_s;
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic pred(input logic pt);
        step(1'b1, pt, 1'b0, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        idle();
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0;
        ghr  = 8'h00;
        i_pred_valid = 1'b0; i_pred_taken = 1'b0; i_cmt_valid = 1'b0;
        i_mis_valid  = 1'b0; i_mis_tag    = 3'd0; i_mis_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state, with a prediction offered that must be refused.
        step(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        rstn = 1'b1;

        // Consecutive predictions T, NT, T from an all-zero history.
        ghr = 8'h00;
        pred(1'b1);
        chk("seq_wdata0", 32'(ghr), 32'h01);
        pred(1'b0);
        chk("seq_wdata1", 32'(ghr), 32'h02);
        pred(1'b1);
        chk("seq_wdata2", 32'(ghr), 32'h05);
        idle();

        // Fill to capacity, refuse a ninth, then wrap after a commit.
        do_reset();
        ghr = 8'hA5;
        for (int i = 0; i < 8; i++) pred(1'($urandom_range(0, 1)));
        step(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        chk("wrap_count", 32'(o_ckpt_count), 32'd7);
        pred(1'b1);

        // Mispredict of tag 1 after four allocations from 0x3C.
        do_reset();
        ghr = 8'h3C;
        pred(1'b1);
        pred(1'b0);
        pred(1'b1);
        pred(1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0);
        chk("mis_restore", 32'(ghr), 32'hF2);
        chk("mis_count", 32'(o_ckpt_count), 32'd2);
        pred(1'b0);

        // Mispredict with a simultaneous prediction: allocation refused.
        step(1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 1'b1);
        pred(1'b1);

        // Commit and mispredict of the oldest entry with a single live entry.
        do_reset();
        ghr = 8'h81;
        pred(1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1);
        chk("cm_empty", 32'(o_empty), 32'd1);
        chk("cm_ghr", 32'(ghr), 32'h03);
        idle();

        // Reset with five live checkpoints.
        ghr = 8'h5A;
        for (int i = 0; i < 5; i++) pred(1'($urandom_range(0, 1)));
        rstn = 1'b0;
        step(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        rstn = 1'b1;
        idle();

        // Randomised traffic against the model.
        for (int n = 0; n < 600; n++) begin
            logic       pv, pt, cv, mv, mtk;
            logic [2:0] mt;
            int         sz;
            sz  = q.size();
            pv  = ($urandom_range(0, 3) != 0);
            pt  = 1'($urandom_range(0, 1));
            cv  = (sz > 0) && ($urandom_range(0, 2) == 0);
            mv  = (sz > 0) && ($urandom_range(0, 9) == 0);
            mtk = 1'($urandom_range(0, 1));
            mt  = 3'((head + ((sz > 0) ? int'($urandom_range(0, sz - 1)) : 0)) % 8);
            rstn = ($urandom_range(0, 99) != 0);
            if (!rstn) mv = 1'b0;
            step(pv, pt, cv, mv, mt, mtk);
            rstn = 1'b1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
